// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle RV32M divide/remainder sequencer (DIV, DIVU, REM, REMU).
// Restoring shift-subtract datapath, one quotient bit per cycle, with RISC-V sign
// fixup and special-case overrides (divide by zero, signed overflow).
// Optional feature macro: DIV_FAST_SPECIAL_EN -- when defined, divide-by-zero and
// signed overflow skip CALC and return one cycle after acceptance.
module div_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic [4:0]            rd_i,
  input  logic                  kill_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [4:0]            rd_o
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  localparam logic [DATA_WIDTH-1:0] MinNeg  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  LastCnt = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                  state_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    is_rem_q;
  logic                    a_neg_q;
  logic                    b_neg_q;
  logic [DATA_WIDTH-1:0]   dvd_q;   // original dividend, needed for the div-by-zero remainder
  logic [DATA_WIDTH-1:0]   dsr_q;   // divisor magnitude
  logic [DATA_WIDTH-1:0]   rem_q;
  logic [DATA_WIDTH-1:0]   quo_q;

  logic                    in_signed;
  logic                    a_neg_in;
  logic                    b_neg_in;
  logic [DATA_WIDTH-1:0]   a_abs_in;
  logic [DATA_WIDTH-1:0]   b_abs_in;

  logic [DATA_WIDTH:0]     shifted;
  logic [DATA_WIDTH:0]     trial;
  logic                    trial_ok;
  logic [DATA_WIDTH-1:0]   rem_nxt;
  logic [DATA_WIDTH-1:0]   quo_nxt;

  // Final result: special-case overrides first, then sign fixup of the magnitudes.
  function automatic logic [DATA_WIDTH-1:0] finalize(
    input logic                  is_rem,
    input logic                  a_neg,
    input logic                  b_neg,
    input logic [DATA_WIDTH-1:0] dvd,
    input logic [DATA_WIDTH-1:0] dsr_abs,
    input logic [DATA_WIDTH-1:0] q,
    input logic [DATA_WIDTH-1:0] r
  );
    logic div0;
    logic ovf;
    div0 = (dsr_abs == '0);
    // Sign flags are only ever set for signed ops, so this implies a signed op.
    ovf  = a_neg && b_neg && (dvd == MinNeg) && (dsr_abs == DATA_WIDTH'(1));
    if (div0) begin
      finalize = is_rem ? dvd : '1;
    end else if (ovf) begin
      finalize = is_rem ? '0 : MinNeg;
    end else if (is_rem) begin
      finalize = a_neg ? -r : r;
    end else begin
      finalize = (a_neg ^ b_neg) ? -q : q;
    end
  endfunction

  // Operand magnitudes and signs at acceptance.
  always_comb begin
    in_signed = ~op_i[0];
    a_neg_in  = in_signed & dividend_i[DATA_WIDTH-1];
    b_neg_in  = in_signed & divisor_i[DATA_WIDTH-1];
    a_abs_in  = a_neg_in ? -dividend_i : dividend_i;
    b_abs_in  = b_neg_in ? -divisor_i : divisor_i;
  end

  // One restoring step: shift {rem,quo} left, trial-subtract in DATA_WIDTH+1 bits.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_WIDTH-1]};
    trial    = shifted - {1'b0, dsr_q};
    trial_ok = ~trial[DATA_WIDTH];
    rem_nxt  = trial_ok ? trial[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
    quo_nxt  = {quo_q[DATA_WIDTH-2:0], trial_ok};
  end

`ifdef DIV_FAST_SPECIAL_EN
  logic fast_special;

  // Special cases are known from the raw operands and need no iteration.
  always_comb begin
    fast_special = (divisor_i == '0) ||
                   (in_signed && (dividend_i == MinNeg) && (divisor_i == '1));
  end
`endif

  // Sequencer FSM with registered busy/ready/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      busy_o   <= 1'b0;
      ready_o  <= 1'b0;
      result_o <= '0;
      rd_o     <= '0;
    end else begin
      ready_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i && !kill_i) begin
            is_rem_q <= op_i[1];
            a_neg_q  <= a_neg_in;
            b_neg_q  <= b_neg_in;
            dvd_q    <= dividend_i;
            dsr_q    <= b_abs_in;
            rem_q    <= '0;
            quo_q    <= a_abs_in;
            cnt_q    <= '0;
            rd_o     <= rd_i;
            busy_o   <= 1'b1;
            state_q  <= StCalc;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_special) begin
              result_o <= finalize(op_i[1], a_neg_in, b_neg_in, dividend_i, b_abs_in,
                                   '0, '0);
              ready_o  <= 1'b1;
              state_q  <= StDone;
            end
`endif
          end
        end
        StCalc: begin
          if (kill_i) begin
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
            if (cnt_q == LastCnt) begin
              result_o <= finalize(is_rem_q, a_neg_q, b_neg_q, dvd_q, dsr_q,
                                   quo_nxt, rem_nxt);
              ready_o  <= 1'b1;
              state_q  <= StDone;
            end
          end
        end
        StDone: begin
          // The pulse is already on the wire; kill or not, return to idle.
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: table-driven directed vectors for div_ctrl plus hand-written
// sequences for kill, ignored start, mid-operation reset and back-to-back issue.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_i;
  logic        kill_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  div_ctrl #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_i       (rd_i),
    .kill_i     (kill_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[18];

  // Advance to 1 time unit after the next rising edge (drive and sample phase).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int exp_latency(input bit special);
`ifdef DIV_FAST_SPECIAL_EN
    return special ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  // Issue one op from idle and check latency, result, tag and busy profile.
  task automatic run_op(input string name, input vec_t v);
    int cyc;
    int rdy_cyc;
    bit busy_ok;
    op_i       = v.op;
    dividend_i = v.a;
    divisor_i  = v.b;
    rd_i       = v.rd;
    start_i    = 1'b1;
    step();
    start_i = 1'b0;
    cyc     = 1;
    rdy_cyc = -1;
    busy_ok = 1'b1;
    while (cyc <= 40) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (ready_o === 1'b1) begin
        rdy_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    check({name, " latency"}, rdy_cyc, exp_latency(v.special));
    check({name, " result"}, result_o, v.exp);
    check({name, " rd"}, {27'd0, rd_o}, {27'd0, v.rd});
    check({name, " busy_until_ready"}, {31'd0, busy_ok}, 32'd1);
    step();
    check({name, " ready_drops"}, {31'd0, ready_o}, 32'd0);
    check({name, " busy_drops"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int n_rdy;
    int first_rdy;
    int second_rdy;
    logic [31:0] first_res;
    logic [4:0]  first_rd;

    vecs[0]  = '{2'd0, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0};
    vecs[1]  = '{2'd2, 32'd100,        32'd7,          5'd6,  32'd2,          1'b0};
    vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{2'd1, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'h7FFF_FFFC,  1'b0};
    vecs[5]  = '{2'd3, 32'hFFFF_FFF9,  32'd2,          5'd10, 32'd1,          1'b0};
    vecs[6]  = '{2'd1, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1'b1};
    vecs[7]  = '{2'd3, 32'd5,          32'd0,          5'd12, 32'd5,          1'b1};
    vecs[8]  = '{2'd0, 32'hFFFF_FFFB,  32'd0,          5'd13, 32'hFFFF_FFFF,  1'b1};
    vecs[9]  = '{2'd2, 32'hFFFF_FFFB,  32'd0,          5'd14, 32'hFFFF_FFFB,  1'b1};
    vecs[10] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'h8000_0000,  1'b1};
    vecs[11] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          1'b1};
    vecs[12] = '{2'd0, 32'd7,          32'hFFFF_FFFE,  5'd17, 32'hFFFF_FFFD,  1'b0};
    vecs[13] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  5'd18, 32'd1,          1'b0};
    vecs[14] = '{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd19, 32'd14,         1'b0};
    vecs[15] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd20, 32'd0,          1'b0};
    vecs[16] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  5'd21, 32'h8000_0000,  1'b0};
    vecs[17] = '{2'd0, 32'h8000_0000,  32'd1,          5'd22, 32'h8000_0000,  1'b0};

    rst        = 1'b1;
    start_i    = 1'b0;
    kill_i     = 1'b0;
    op_i       = 2'd0;
    dividend_i = '0;
    divisor_i  = '0;
    rd_i       = '0;
    step();
    step();
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset ready", {31'd0, ready_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    check("reset rd", {27'd0, rd_o}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 18; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Kill during CALC at cycle 10: busy falls at cycle 11, no ready ever.
    op_i = 2'd0; dividend_i = 32'd100; divisor_i = 32'd7; rd_i = 5'd3;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) step();
    check("kill busy_before", {31'd0, busy_o}, 32'd1);
    kill_i = 1'b1;
    step();
    kill_i = 1'b0;
    check("kill busy_after", {31'd0, busy_o}, 32'd0);
    n_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready_o === 1'b1) n_rdy++;
      step();
    end
    check("kill no_ready", n_rdy, 0);

    // kill beats start in the same idle cycle.
    start_i = 1'b1;
    kill_i  = 1'b1;
    step();
    start_i = 1'b0;
    kill_i  = 1'b0;
    check("kill_vs_start busy", {31'd0, busy_o}, 32'd0);
    step();

    // A second start at cycle 5 is ignored.
    op_i = 2'd0; dividend_i = 32'd100; divisor_i = 32'd7; rd_i = 5'd5;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 5; c++) step();
    op_i = 2'd2; dividend_i = 32'd9; divisor_i = 32'd3; rd_i = 5'd9;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    n_rdy = 0; first_rdy = -1; first_res = '0; first_rd = '0;
    for (int c = 6; c <= 75; c++) begin
      if (ready_o === 1'b1) begin
        if (n_rdy == 0) begin
          first_rdy = c;
          first_res = result_o;
          first_rd  = rd_o;
        end
        n_rdy++;
      end
      step();
    end
    check("ignore ready_count", n_rdy, 1);
    check("ignore ready_cycle", first_rdy, 33);
    check("ignore result", first_res, 32'd14);
    check("ignore rd", {27'd0, first_rd}, 32'd5);

    // Reset at cycle 20 mid-CALC: all outputs zero next cycle, no ready after.
    op_i = 2'd1; dividend_i = 32'd1000; divisor_i = 32'd3; rd_i = 5'd25;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst busy", {31'd0, busy_o}, 32'd0);
    check("midrst ready", {31'd0, ready_o}, 32'd0);
    check("midrst result", result_o, 32'd0);
    check("midrst rd", {27'd0, rd_o}, 32'd0);
    n_rdy = 0;
    for (int c = 0; c < 40; c++) begin
      if (ready_o === 1'b1) n_rdy++;
      step();
    end
    check("midrst no_ready", n_rdy, 0);
    run_op("post_reset div", '{2'd0, 32'd9, 32'd3, 5'd4, 32'd3, 1'b0});

    // start held continuously: accepted at cycle 0 and again at cycle 34.
    op_i = 2'd1; dividend_i = 32'd100; divisor_i = 32'd7; rd_i = 5'd30;
    start_i = 1'b1;
    step();
    n_rdy = 0; first_rdy = -1; second_rdy = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 35) start_i = 1'b0;
      if (ready_o === 1'b1) begin
        if (n_rdy == 0) first_rdy = c;
        else if (n_rdy == 1) second_rdy = c;
        n_rdy++;
        check($sformatf("b2b result%0d", n_rdy), result_o, 32'd14);
      end
      step();
    end
    start_i = 1'b0;
    check("b2b ready_count", n_rdy, 2);
    check("b2b first_cycle", first_rdy, 33);
    check("b2b second_cycle", second_rdy, 67);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
